// File: rtl/work_steal_executor_if.sv
// Steal executor bus: scheduler command, queue pop port, queue push port.
// The stat_* counters exist only when STEAL_STATS_EN is defined.
interface work_steal_executor_if #(
  parameter int NUM_PU            = 16,
  parameter int QUEUE_DEPTH_WIDTH = 10,
  parameter int DATA_WIDTH        = 32
);
  localparam int PU_W = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;

  // scheduler command and status
  logic                                steal_request;
  logic [PU_W-1:0]                     steal_from;
  logic [PU_W-1:0]                     steal_to;
  logic [NUM_PU*QUEUE_DEPTH_WIDTH-1:0] pe_queue_depths;
  logic                                steal_busy;
  logic                                steal_done;
  logic [7:0]                          steal_count;
  // victim queue pop port
  logic                                pop_req;
  logic [PU_W-1:0]                     pop_pu;
  logic                                pop_ack;
  logic                                pop_empty;
  logic [DATA_WIDTH-1:0]               pop_data;
  // thief queue push port
  logic                                push_valid;
  logic [PU_W-1:0]                     push_pu;
  logic [DATA_WIDTH-1:0]               push_data;
  logic                                push_ready;
`ifdef STEAL_STATS_EN
  logic [31:0]                         stat_steals;
  logic [31:0]                         stat_items;
`endif

  modport slave (
`ifdef STEAL_STATS_EN
    output stat_steals, stat_items,
`endif
    input  steal_request, steal_from, steal_to, pe_queue_depths,
    input  pop_ack, pop_empty, pop_data, push_ready,
    output steal_busy, steal_done, steal_count,
    output pop_req, pop_pu, push_valid, push_pu, push_data
  );

  modport master (
`ifdef STEAL_STATS_EN
    input  stat_steals, stat_items,
`endif
    output steal_request, steal_from, steal_to, pe_queue_depths,
    output pop_ack, pop_empty, pop_data, push_ready,
    input  steal_busy, steal_done, steal_count,
    input  pop_req, pop_pu, push_valid, push_pu, push_data
  );
endinterface

// File: rtl/work_steal_executor.sv
// Work-steal executor: moves up to MAX_BATCH entries from a victim queue to a
// thief queue, one pop followed by one push per entry, through a one-entry
// holding register. Optional statistics counters guarded by STEAL_STATS_EN.
module work_steal_executor #(
  parameter int NUM_PU            = 16,
  parameter int QUEUE_DEPTH_WIDTH = 10,
  parameter int DATA_WIDTH        = 32,
  parameter int MAX_BATCH         = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  work_steal_executor_if.slave  bus
);
  localparam int PU_W = (NUM_PU > 1) ? $clog2(NUM_PU) : 1;
  // batch limit comparison is done at the wider of depth width and 8 bits
  localparam int CW   = (QUEUE_DEPTH_WIDTH > 8) ? QUEUE_DEPTH_WIDTH : 8;

  typedef enum logic [1:0] {S_IDLE, S_POP, S_PUSH, S_DONE} state_t;

  state_t                       r_state;
  state_t                       w_next;
  logic [PU_W-1:0]              r_from;
  logic [PU_W-1:0]              r_to;
  logic [7:0]                   r_batch;
  logic [7:0]                   r_count;
  logic [7:0]                   r_last_count;
  logic [DATA_WIDTH-1:0]        r_hold;
  logic [QUEUE_DEPTH_WIDTH-1:0] w_depth_from;
  logic [7:0]                   w_batch;
  logic [7:0]                   w_count_inc;
  logic                         w_accept;

  // min(MAX_BATCH, depth/2) evaluated before narrowing to 8 bits
  function automatic logic [7:0] batch_size(input logic [QUEUE_DEPTH_WIDTH-1:0] depth);
    logic [CW-1:0] half;
    logic [CW-1:0] cap;
    half = CW'(depth >> 1);
    cap  = CW'(MAX_BATCH);
    return (half < cap) ? half[7:0] : cap[7:0];
  endfunction

  assign w_batch     = batch_size(w_depth_from);
  assign w_count_inc = r_count + 8'd1;
  assign w_accept    = (r_state == S_IDLE) && bus.steal_request &&
                       (bus.steal_from != bus.steal_to);

  assign bus.pop_pu      = r_from;
  assign bus.push_pu     = r_to;
  assign bus.push_data   = r_hold;
  assign bus.steal_count = r_last_count;

  // select the victim's depth field from the flattened depth vector
  always_comb begin
    w_depth_from = '0;
    for (int k = 0; k < NUM_PU; k++) begin
      if (bus.steal_from == PU_W'(k))
        w_depth_from = bus.pe_queue_depths[k*QUEUE_DEPTH_WIDTH +: QUEUE_DEPTH_WIDTH];
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next-state: one pop then one push per entry until batch reached or victim empty
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept)       w_next = (w_batch == 8'd0) ? S_DONE : S_POP;
      S_POP:  if (bus.pop_ack)    w_next = bus.pop_empty ? S_DONE : S_PUSH;
      S_PUSH: if (bus.push_ready) w_next = (w_count_inc == r_batch) ? S_DONE : S_POP;
      S_DONE:                     w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  // state-decoded handshake and status outputs
  always_comb begin
    bus.steal_busy = 1'b0;
    bus.steal_done = 1'b0;
    bus.pop_req    = 1'b0;
    bus.push_valid = 1'b0;
    case (r_state)
      S_POP:  begin bus.steal_busy = 1'b1; bus.pop_req    = 1'b1; end
      S_PUSH: begin bus.steal_busy = 1'b1; bus.push_valid = 1'b1; end
      S_DONE: begin bus.steal_busy = 1'b1; bus.steal_done = 1'b1; end
      default: ;
    endcase
  end

  // command latch, holding register, progress and result counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_from       <= '0;
      r_to         <= '0;
      r_batch      <= '0;
      r_count      <= '0;
      r_last_count <= '0;
      r_hold       <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_from  <= bus.steal_from;
          r_to    <= bus.steal_to;
          r_batch <= w_batch;
          r_count <= 8'd0;
          if (w_batch == 8'd0) r_last_count <= 8'd0;
        end
        S_POP: if (bus.pop_ack) begin
          if (bus.pop_empty) r_last_count <= r_count;
          else               r_hold       <= bus.pop_data;
        end
        S_PUSH: if (bus.push_ready) begin
          r_count <= w_count_inc;
          if (w_count_inc == r_batch) r_last_count <= w_count_inc;
        end
        default: ;
      endcase
    end
  end

`ifdef STEAL_STATS_EN
  logic [31:0] r_stat_steals;
  logic [31:0] r_stat_items;
  logic [32:0] w_items_sum;

  assign w_items_sum     = {1'b0, r_stat_items} + {25'd0, r_last_count};
  assign bus.stat_steals = r_stat_steals;
  assign bus.stat_items  = r_stat_items;

  // saturating steal/item counters, updated in the completion cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_steals <= '0;
      r_stat_items  <= '0;
    end else if (r_state == S_DONE) begin
      if ((r_last_count != 8'd0) && (r_stat_steals != '1))
        r_stat_steals <= r_stat_steals + 32'd1;
      r_stat_items <= w_items_sum[32] ? '1 : w_items_sum[31:0];
    end
  end
`endif

endmodule
